// File: rtl/camera_pkg.sv
// camera_pkg
//   Shared camera constants and the capture FSM state encoding.
//   FRAME_W/FRAME_H : sensor geometry (VGA)
//   FRAME_PIXELS    : pixels per frame
//   PIX_ADDR_W      : width of a linear pixel address
//   capture_state_t : IDLE / ARMED / CAPTURE / DONE
package camera_pkg;

  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 480;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int PIX_ADDR_W   = 19;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } capture_state_t;

endpackage

// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
//   Captures whole camera frames into a frame buffer. Capture only ever begins
//   at pixel address 0. From there, every valid pixel must arrive in address
//   order. A pixel that arrives out of order is dropped, the sticky error flag
//   is set, and the block waits for the next frame start.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   start, stop         : one-cycle control requests
//   continuous          : free-run (1) or single frame (0), sampled with start
//   pixelValid          : qualifies the pixel inputs
//   pixelAddress        : linear address of the pixel
//   pixelData           : pixel value
//   wrEn/wrAddr/wrData  : registered frame-buffer write port, 1-cycle latency
//   busy                : ARMED or CAPTURE
//   done                : DONE
//   frameError          : sticky out-of-order pixel flag
//   frameCount          : completed frames, wraps at 16 bits
//   state_dbg           : registered FSM state
//
// Handshake: the camera side has no back-pressure. A pixel is consumed in any
// cycle where pixelValid=1. Each accepted pixel produces exactly one wrEn
// pulse in the next cycle, and the frame buffer must take it unconditionally.
module frame_capture_ctrl
  import camera_pkg::*;
#(
  parameter int FRAME_PIXELS = camera_pkg::FRAME_PIXELS,
  parameter int ADDR_W       = camera_pkg::PIX_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic                 pixelValid,
  input  logic [ADDR_W-1:0]    pixelAddress,
  input  logic [15:0]          pixelData,
  output logic                 wrEn,
  output logic [ADDR_W-1:0]    wrAddr,
  output logic [15:0]          wrData,
  output logic                 busy,
  output logic                 done,
  output logic                 frameError,
  output logic [15:0]          frameCount,
  output capture_state_t       state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

  capture_state_t      state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   exp_q, exp_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                err_q, err_d;
  logic [15:0]         count_q, count_d;

  // Working signals for the write decision in the current cycle.
  logic accept;
  logic mode_eff;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    exp_d     = exp_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    count_d   = count_q;
    accept    = 1'b0;
    mode_eff  = mode_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A start that arrives together with stop is treated as a
        // contradictory request and is dropped.
        if (start && !stop) begin
          state_d = ST_ARMED;
          mode_d  = continuous;
          err_d   = 1'b0;
          exp_d   = '0;
        end
      end
      ST_ARMED: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pixelValid && (pixelAddress == '0)) begin
          accept = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Graceful stop: free-run ends after the current frame. mode_eff lets
        // a stop that coincides with the last pixel take effect immediately.
        if (stop) begin
          mode_d   = 1'b0;
          mode_eff = 1'b0;
        end
        if (pixelValid) begin
          if (pixelAddress == exp_q) begin
            accept = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ARMED;
            exp_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pixelAddress;
      wr_data_d = pixelData;
      if (pixelAddress == LAST_ADDR) begin
        count_d = count_q + 16'd1;
        exp_d   = '0;
        state_d = mode_eff ? ST_CAPTURE : ST_DONE;
      end else begin
        exp_d   = pixelAddress + 1'b1;
        state_d = ST_CAPTURE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      exp_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      exp_q     <= exp_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign wrEn       = wr_en_q;
  assign wrAddr     = wr_addr_q;
  assign wrData     = wr_data_q;
  assign busy       = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign done       = (state_q == ST_DONE);
  assign frameError = err_q;
  assign frameCount = count_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
module tb_frame_capture_ctrl;
  import camera_pkg::*;

  localparam int FP = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          continuous = 1'b0;
  logic          pixelValid = 1'b0;
  logic [AW-1:0] pixelAddress = '0;
  logic [15:0]   pixelData = '0;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [15:0]   wrData;
  logic          busy;
  logic          done;
  logic          frameError;
  logic [15:0]   frameCount;
  capture_state_t state_dbg;

  int checks = 0;
  int errors = 0;

  logic [AW+16-1:0] exp_q[$];

  frame_capture_ctrl #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .continuous(continuous), .pixelValid(pixelValid),
    .pixelAddress(pixelAddress), .pixelData(pixelData),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .busy(busy),
    .done(done), .frameError(frameError), .frameCount(frameCount),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (wrEn) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                 wrAddr, wrData);
      end else begin
        logic [AW+16-1:0] e;
        e = exp_q.pop_front();
        if ({wrAddr, wrData} !== e) begin
          errors++;
          $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   wrAddr, wrData, e[AW+16-1:16], e[15:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one pixel for one cycle; wr says whether it must be written
  task automatic pix(input int addr, input bit wr);
    pixelValid   = 1'b1;
    pixelAddress = AW'(addr);
    pixelData    = 16'($urandom_range(0, 65535));
    if (wr) exp_q.push_back({pixelAddress, pixelData});
    tick();
    pixelValid = 1'b0;
  endtask

  task automatic feed(input int lo, input int hi, input bit wr);
    for (int a = lo; a <= hi; a++) pix(a, wr);
  endtask

  task automatic pulse_start(input bit cont);
    start = 1'b1;
    continuous = cont;
    tick();
    start = 1'b0;
    continuous = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic check_status(input string tag, input int st, input int bsy,
                              input int dn, input int cnt);
    check({tag, "_state"}, int'(state_dbg), st);
    check({tag, "_busy"}, int'(busy), bsy);
    check({tag, "_done"}, int'(done), dn);
    check({tag, "_count"}, int'(frameCount), cnt);
  endtask

  typedef struct {
    logic       start, stop, cont, valid;
    logic [5:0] addr;
    logic       exp_wr;
    logic [1:0] exp_state;
    logic       exp_busy, exp_done, exp_err;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // single-cycle behaviour table, applied from IDLE after reset
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    // reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_wren", int'(wrEn), 0);
    check("rst_wraddr", int'(wrAddr), 0);
    check("rst_wrdata", int'(wrData), 0);
    check("rst_err", int'(frameError), 0);
    check_status("rst", 0, 0, 0, 0);

    // table-driven single-cycle vectors
    for (int i = 0; i < 11; i++) begin
      start        = vecs[i].start;
      stop         = vecs[i].stop;
      continuous   = vecs[i].cont;
      pixelValid   = vecs[i].valid;
      pixelAddress = vecs[i].addr;
      pixelData    = 16'($urandom_range(0, 65535));
      if (vecs[i].exp_wr) exp_q.push_back({pixelAddress, pixelData});
      tick();
      start = 1'b0; stop = 1'b0; continuous = 1'b0; pixelValid = 1'b0;
      check($sformatf("vec%0d_state", i), int'(state_dbg), int'(vecs[i].exp_state));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].exp_done));
      check($sformatf("vec%0d_err", i), int'(frameError), int'(vecs[i].exp_err));
    end

    // single frame
    pulse_start(1'b0);
    feed(0, FP - 1, 1'b1);
    check_status("single", 3, 0, 1, 1);
    feed(0, 3, 1'b0);
    check("single_hold_state", int'(state_dbg), 3);

    // arm mid-frame: wait for next frame start
    pulse_start(1'b0);
    feed(10, FP - 1, 1'b0);
    check("midarm_state", int'(state_dbg), 1);
    feed(0, FP - 1, 1'b1);
    check_status("midarm", 3, 0, 1, 2);

    // continuous: two full frames, stop mid third frame
    pulse_start(1'b1);
    feed(0, FP - 1, 1'b1);
    feed(0, FP - 1, 1'b1);
    check_status("cont2", 2, 1, 0, 4);
    feed(0, 19, 1'b1);
    stop = 1'b1;
    pix(20, 1'b1);
    stop = 1'b0;
    check("cont_stop_state", int'(state_dbg), 2);
    feed(21, FP - 1, 1'b1);
    check_status("cont3", 3, 0, 1, 5);

    // stop together with the last pixel in free-run
    pulse_start(1'b1);
    feed(0, FP - 2, 1'b1);
    stop = 1'b1;
    pix(FP - 1, 1'b1);
    stop = 1'b0;
    check_status("stoplast", 3, 0, 1, 6);

    // skipped pixel forces resync
    pulse_start(1'b0);
    feed(0, 9, 1'b1);
    pix(13, 1'b0);
    check("skip_err", int'(frameError), 1);
    check_status("skip", 1, 1, 0, 6);
    feed(14, FP - 1, 1'b0);
    feed(0, FP - 1, 1'b1);
    check_status("skip_next", 3, 0, 1, 7);
    check("skip_err_sticky", int'(frameError), 1);
    pulse_start(1'b0);
    check("start_clears_err", int'(frameError), 0);

    // reset in the middle of capture
    feed(0, 19, 1'b1);
    reset = 1'b1;
    pix(20, 1'b0);
    reset = 1'b0;
    check("midrst_wren", int'(wrEn), 0);
    check_status("midrst", 0, 0, 0, 0);
    pulse_start(1'b0);
    feed(0, FP - 1, 1'b1);
    check_status("after_rst", 3, 0, 1, 1);

    tick(); tick();
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_capture_ctrl.md
FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 307200, pixels per frame (640*480).
REQ-002 SHALL have parameter ADDR_W, default 19, pixel address width (2^19 > FRAME_PIXELS).
REQ-003 SHALL have port clk  in  1  single clock for the whole block; camera pixel domain.
REQ-004 SHALL have port reset  in  1  reset, synchronous to clk and active-high.
REQ-005 SHALL have port start  in  1  one-cycle request to arm a capture.
REQ-006 SHALL have port stop  in  1  one-cycle request to end capture.
REQ-007 SHALL have port continuous  in  1  mode select, sampled with start: 1 = free-run, 0 = single frame.
REQ-008 SHALL have port pixelValid  in  1  camera pixel qualifier from the coordinate tracker.
REQ-009 SHALL have port pixelAddress  in  ADDR_W  linear address of the current camera pixel.
REQ-010 SHALL have port pixelData  in  16  current camera pixel value.
REQ-011 SHALL have port wrEn  out  1  frame buffer write strobe.
REQ-012 SHALL have port wrAddr  out  ADDR_W  frame buffer write address.
REQ-013 SHALL have port wrData  out  16  frame buffer write data.
REQ-014 SHALL have port busy  out  1  high in ARMED or CAPTURE.
REQ-015 SHALL have port done  out  1  high in DONE.
REQ-016 SHALL have port frameError  out  1  sticky flag for pixel-sequence mismatch.
REQ-017 SHALL have port frameCount  out  16  count of completed frames, wraps at 65535->0.

Function
REQ-018 SHALL implement FSM IDLE, ARMED, CAPTURE, DONE.
REQ-019 IDLE/DONE: start=1 and stop=0 SHALL go to ARMED and latch continuous into modeReg; start with stop=1 SHALL be ignored.
REQ-020 ARMED: stop SHALL return to IDLE; pixelValid with pixelAddress==0 SHALL enter CAPTURE, and that pixel SHALL be written.
REQ-021 ARMED: any other pixelValid SHALL be discarded (mid-frame arming waits for next frame start).
REQ-022 CAPTURE: each pixelValid with pixelAddress==expected SHALL produce wrEn=1, wrAddr=pixelAddress, wrData=pixelData on the next cycle (registered, latency 1); expected SHALL then increment.
REQ-023 wrEn SHALL be 0 in every cycle not covered by REQ-022.
REQ-024 CAPTURE: a valid pixel with pixelAddress!=expected SHALL NOT be written, SHALL set frameError, and SHALL return to ARMED (resync); frameCount SHALL be unchanged.
REQ-025 CAPTURE: a written pixel at FRAME_PIXELS-1 SHALL increment frameCount; if modeReg=1, the FSM SHALL stay in CAPTURE with expected=0; otherwise it SHALL go to DONE.
REQ-026 stop in CAPTURE SHALL clear modeReg; the current frame SHALL complete, then the FSM SHALL go to DONE (graceful stop); start in CAPTURE/ARMED SHALL be ignored.
REQ-027 stop and the last pixel in the same cycle SHALL write the pixel, increment frameCount, and go to DONE.
REQ-028 frameError SHALL clear only on reset or on an accepted start (REQ-019).
REQ-029 busy and done SHALL be decoded from the registered state (no combinational input paths).

Reset
REQ-030 reset SHALL force state=IDLE, modeReg=0, expected=0, wrEn=0, wrAddr=0, wrData=0, frameError=0, frameCount=0, busy=0, done=0 on the next clk edge.
REQ-031 reset SHALL take priority over all inputs, including mid-CAPTURE; a write pending from the previous cycle SHALL NOT be issued.

Structure
REQ-032 Package camera_pkg SHALL hold FRAME_W=640, FRAME_H=480, FRAME_PIXELS, PIX_ADDR_W=19, and the capture_state_t enum.
REQ-033 The block SHALL be single-module, with no sub-module: FSM, expected-address counter and output register only.

Verification
REQ-034 Single frame: start (continuous=0), feed addresses 0..307199 valid -> 307200 writes, wrAddr matching with 1-cycle lag, done=1, frameCount=1.
REQ-035 Arm mid-frame: start while address 1000 streams -> no wrEn until address 0 of the next frame, then a full frame is written.
REQ-036 Continuous mode: 3 frames, stop during frame 3 at address 5000 -> frame 3 completes, frameCount=3, done=1.
REQ-037 Skip: in CAPTURE, expected=100 but address 105 arrives -> no write, frameError=1, state ARMED; the next frame captures normally.
REQ-038 Reset asserted at address 200000 in CAPTURE -> next cycle wrEn=0, busy=0, frameCount=0; a later start resumes normally.
REQ-039 start and stop together in IDLE -> stays IDLE, busy=0.
